// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Imported by the fetch RTL and its bench.
package ifu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD
   } fetch_state_e;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] INSN_NOP = 32'h0000_0013;

   function automatic logic [31:0] align_pc(input logic [31:0] a);
      return a & ~32'd3;
   endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// IFU bus bundle: imem request/grant/response plus the
// IFU->IDU valid/ready stage handshake and execute redirect.
interface ifu_fetch_if;

   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] insn_o;
   logic [31:0] pc_o;
   logic        ifu_valid_o;
   logic        idu_ready_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i,
      output insn_o,
      output pc_o,
      output ifu_valid_o,
      input  idu_ready_i,
      input  redirect_i,
      input  redirect_pc_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i,
      input  insn_o,
      input  pc_o,
      input  ifu_valid_o,
      output idu_ready_i,
      output redirect_i,
      output redirect_pc_i
   );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC, one-outstanding imem fetch, and
// stale-response drop on execute redirect.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR = RESET_PC
) (
   input  logic        clk_i,
   input  logic        rst_i,
   ifu_fetch_if.master bus
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  insn_q, insn_d;
   logic [31:0]  ipc_q, ipc_d;
   logic         drop_q, drop_d;
   logic [31:0]  tgt;

   assign tgt = align_pc(bus.redirect_pc_i);

   // Next-state: FSM walk, PC advance/redirect, drop tracking.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      insn_d  = insn_q;
      ipc_d   = ipc_q;
      drop_d  = drop_q;
      unique case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (bus.imem_gnt_i) begin
               state_d = WAIT;
               drop_d  = bus.redirect_i;
            end
         end
         WAIT: begin
            if (bus.imem_rvalid_i) begin
               if (drop_q || bus.redirect_i) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  insn_d  = bus.imem_rdata_i;
                  ipc_d   = pc_q;
                  state_d = HOLD;
               end
            end else if (bus.redirect_i) begin
               drop_d = 1'b1;
            end
         end
         HOLD: begin
            if (bus.idu_ready_i) begin
               pc_d = pc_q + 32'd4;
            end
            if (bus.idu_ready_i || bus.redirect_i) begin
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
      if (bus.redirect_i) begin
         pc_d = tgt;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         pc_q    <= BOOT_ADDR;
         insn_q  <= 32'd0;
         ipc_q   <= 32'd0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         insn_q  <= insn_d;
         ipc_q   <= ipc_d;
         drop_q  <= drop_d;
      end
   end

   assign bus.imem_req_o  = (state_q == REQ);
   assign bus.imem_addr_o = pc_q;
   assign bus.ifu_valid_o = (state_q == HOLD);
   assign bus.insn_o      = insn_q;
   assign bus.pc_o        = ipc_q;

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit: owns the program counter, issues word fetches to instruction memory over a request/grant/response bus, and presents each fetched instruction with its PC to the decode stage through a valid/ready handshake. It is the IFU end of the IFU→IDU interface. It accepts PC redirects from the execute stage and discards any in-flight fetch made stale by a redirect.

## Interface
- `BOOT_ADDR`, default 32'h8000_0000: PC loaded at reset; must be word-aligned.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `imem_req_o` out 1: fetch request valid.
- `imem_addr_o` out 32: fetch word address; equals current PC.
- `imem_gnt_i` in 1: request accepted this cycle.
- `imem_rvalid_i` in 1: response data valid. At most one outstanding request.
- `imem_rdata_i` in 32: fetched instruction word.
- `insn_o` out 32: instruction to decode.
- `pc_o` out 32: PC of `insn_o`.
- `ifu_valid_o` out 1: `insn_o`/`pc_o` valid.
- `idu_ready_i` in 1: decode accepts this cycle.
- `redirect_i` in 1: execute-stage PC redirect (branch/jump taken).
- `redirect_pc_i` in 32: redirect target; bits [1:0] are forced to 0.

## Operation
- States: IDLE, REQ, WAIT, HOLD. Reset puts the FSM in IDLE, PC at `BOOT_ADDR`, `insn_o`/`pc_o` at 0, and the drop flag at 0.
- IDLE: all outputs are deasserted. Next state is REQ unconditionally.
- REQ: `imem_req_o`=1 and `imem_addr_o`=PC. On `imem_gnt_i` the FSM moves to WAIT; otherwise it stays in REQ, holding address stable.
- WAIT: on `imem_rvalid_i` with drop=0, the FSM latches `insn_o`←rdata and `pc_o`←PC, then moves to HOLD. With drop=1, it discards the data, clears drop and moves to REQ.
- HOLD: `ifu_valid_o`=1 and outputs are held stable. On `idu_ready_i` (handshake) PC←PC+4 (mod 2^32, wraps from 32'hFFFF_FFFC to 0) and the FSM moves to REQ.
- A redirect (`redirect_i`=1) always sets PC←{redirect_pc_i[31:2],2'b00} and overrides PC+4. Per state:
  - IDLE: the FSM still moves to REQ.
  - REQ without gnt: the FSM stays in REQ, and the new address appears next cycle.
  - REQ with gnt in the same cycle: the FSM moves to WAIT with drop=1.
  - WAIT without rvalid: drop is set to 1.
  - WAIT with rvalid in the same cycle: the data is discarded and the FSM moves to REQ.
  - HOLD: the FSM moves to REQ. If `idu_ready_i` is also high, the handshake completes normally, because `ifu_valid_o` is not masked by redirect. Either way the next fetch is at the target.
- `rst_i` asserted in any state overrides everything: IDLE, PC=`BOOT_ADDR`, drop=0. A response arriving after reset is ignored, because IDLE/REQ do not sample `imem_rvalid_i`.
- `imem_rvalid_i` in any state other than WAIT is ignored.

## Timing
- `imem_req_o`, `imem_addr_o` and `ifu_valid_o` are decoded from registered state only. There is no combinational path from any input to any output.
- Best-case sequence with gnt in REQ and rvalid the following cycle: REQ(c0) → WAIT(c1) → HOLD(c2). `ifu_valid_o` is high in c2.
- With `idu_ready_i` held high, the next REQ is in c3. Peak throughput is 1 instruction per 3 cycles.
- First request after reset: reset released at edge e0, IDLE for one cycle, `imem_req_o` high from e1.
- A redirect in cycle n takes effect as follows: `imem_addr_o`=target no later than the first REQ cycle after n; no stale instruction is ever presented with `ifu_valid_o`.

## Structure
- Shared package `ifu_pkg`:
  - state enum (IDLE, REQ, WAIT, HOLD);
  - `RESET_PC` constant (default for `BOOT_ADDR`);
  - `INSN_NOP` = 32'h0000_0013, for bench use.
- Single module; no sub-module needed. PC register, drop flag, output registers and FSM all live in `ifu_fetch`.

## Test plan
- Reset, then gnt immediately and rvalid next cycle with rdata=32'h0050_0093, `idu_ready_i`=1 → `imem_addr_o`=32'h8000_0000 in the first REQ cycle; `ifu_valid_o`=1 with `insn_o`=32'h0050_0093 and `pc_o`=32'h8000_0000; next `imem_addr_o`=32'h8000_0004.
- Backpressure: `idu_ready_i`=0 for 5 cycles in HOLD → `insn_o`/`pc_o` stable, `ifu_valid_o` high, no new `imem_req_o`; ready=1 → next REQ at PC+4.
- Gnt stall: `imem_gnt_i`=0 for 4 cycles → `imem_req_o` held high with address unchanged.
- Redirect in WAIT to 32'h8000_0102 → address issued is 32'h8000_0100; the pending response is discarded (`ifu_valid_o` stays 0); the next REQ address is 32'h8000_0100.
- Redirect in the same cycle as gnt → the following rvalid is dropped; the next fetch is at the target.
- Wrap-around: redirect to 32'hFFFF_FFFC, then complete one handshake → next `imem_addr_o`=32'h0000_0000. Separately, `rst_i` mid-WAIT → IDLE, then REQ at `BOOT_ADDR`, and a late rvalid is ignored.
